seg14_scroll_buffer: RTL and testbench

Upstream character source for the 12-digit, 14-segment multiplexed display scanner. It accepts 6-bit character codes over a valid/ready stream into a small FIFO and scrolls them right-to-left through a 12-character window at a programmable rate. It returns the registered 14-segment glyph for whichever digit index the scanner presents, so the scanner no longer carries hardwired text.

---
 rtl/seg14_scroll_buffer.sv | 158 +++++++++++++++
 tb/tb_seg14_scroll_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg14_scroll_buffer.sv
// Character FIFO feeding a 12-digit right-to-left scrolling window, with a
// registered 14-segment glyph lookup for the digit the scanner is driving.
module seg14_scroll_buffer #(
    parameter int DIGITS     = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int SCROLL_DIV = 1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [5:0]                    in_char,
    input  logic                          scroll_en,
    input  logic [3:0]                    digit_idx,
    output logic [13:0]                   segm,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam int             CW       = $clog2(SCROLL_DIV);
    localparam logic [CW-1:0]  DIV_MAX  = CW'(SCROLL_DIV - 1);
    localparam logic [CW-1:0]  DIV_ONE  = CW'(1);
    localparam logic [AW:0]    PTR_ONE  = (AW+1)'(1);
    localparam logic [3:0]     LAST_IDX = 4'(DIGITS - 1);
    localparam logic [5:0]     SPACE    = 6'd36;

    // Segment order, MSB first: a b c d e f g1 g2 | h i j k l m
    function automatic logic [13:0] font(input logic [5:0] code);
        logic [13:0] g;
        case (code)
            6'd0:  g = 14'b11101111_000000; // A
            6'd1:  g = 14'b11110001_010010; // B
            6'd2:  g = 14'b10011100_000000; // C
            6'd3:  g = 14'b11110000_010010; // D
            6'd4:  g = 14'b10011110_000000; // E
            6'd5:  g = 14'b10001110_000000; // F
            6'd6:  g = 14'b10111101_000000; // G
            6'd7:  g = 14'b01101111_000000; // H
            6'd8:  g = 14'b10010000_010010; // I
            6'd9:  g = 14'b01111000_000000; // J
            6'd10: g = 14'b00001110_001100; // K
            6'd11: g = 14'b00011100_000000; // L
            6'd12: g = 14'b01101100_101000; // M
            6'd13: g = 14'b01101100_100100; // N
            6'd14: g = 14'b11111100_000000; // O
            6'd15: g = 14'b11001111_000000; // P
            6'd16: g = 14'b11111100_000100; // Q
            6'd17: g = 14'b11001111_000100; // R
            6'd18: g = 14'b10110111_000000; // S
            6'd19: g = 14'b10000000_010010; // T
            6'd20: g = 14'b01111100_000000; // U
            6'd21: g = 14'b00001100_001001; // V
            6'd22: g = 14'b01101100_000101; // W
            6'd23: g = 14'b00000000_101101; // X
            6'd24: g = 14'b00000000_101010; // Y
            6'd25: g = 14'b10010000_001001; // Z
            6'd26: g = 14'b11111100_001001; // 0
            6'd27: g = 14'b01100000_001000; // 1
            6'd28: g = 14'b11011011_000000; // 2
            6'd29: g = 14'b11110001_000000; // 3
            6'd30: g = 14'b01100111_000000; // 4
            6'd31: g = 14'b10110111_000000; // 5
            6'd32: g = 14'b10111111_000000; // 6
            6'd33: g = 14'b11100000_000000; // 7
            6'd34: g = 14'b11111111_000000; // 8
            6'd35: g = 14'b11110111_000000; // 9
            default: g = '0;
        endcase
        return g;
    endfunction

    logic [5:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] div_q, div_d;
    logic [5:0]    win_q [DIGITS];
    logic [5:0]    win_d [DIGITS];
    logic [13:0]   segm_q, segm_d;
    logic          empty, full, tick, push, pop;

    // The extra pointer bit separates full from empty; the level MSB is set only when full.
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign empty      = (fifo_level == '0);
    assign full       = fifo_level[AW];
    assign in_ready   = !full;
    assign busy       = !empty;
    assign segm       = segm_q;

    assign tick = scroll_en && (div_q == DIV_MAX);
    assign push = in_valid && in_ready && !clr;
    assign pop  = tick && !empty && !clr;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        div_d = div_q + DIV_ONE;
        if (clr || !scroll_en || tick) begin
            div_d = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            win_d[i] = win_q[i];
        end
        if (clr) begin
            for (int i = 0; i < DIGITS; i++) begin
                win_d[i] = SPACE;
            end
        end else if (tick) begin
            for (int i = 0; i < DIGITS - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[DIGITS-1] = empty ? SPACE : mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_comb begin
        segm_d = '0;
        if (digit_idx <= LAST_IDX) begin
            segm_d = font(win_q[digit_idx]);
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= in_char;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            div_q    <= '0;
            segm_q   <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                win_q[i] <= SPACE;
            end
        end else begin
            if (clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            div_q  <= div_d;
            segm_q <= segm_d;
            for (int i = 0; i < DIGITS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

endmodule

// File: tb/tb_seg14_scroll_buffer.sv
// Directed bench for seg14_scroll_buffer with a fast scroll divider (4 cycles per step).
module tb_seg14_scroll_buffer;

    localparam logic [13:0] G_A    = 14'b11101111_000000;
    localparam logic [13:0] G_L    = 14'b00011100_000000;
    localparam logic [13:0] G_N    = 14'b01101100_100100;
    localparam logic [13:0] G_O    = 14'b11111100_000000;
    localparam logic [13:0] G_Z    = 14'b10010000_001001;
    localparam logic [13:0] G_ZERO = 14'b11111100_001001;

    typedef struct {
        logic [3:0]  idx;
        logic [13:0] exp_segm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_ready, scroll_en, busy;
    logic [5:0]  in_char;
    logic [3:0]  digit_idx;
    logic [13:0] segm;
    logic [4:0]  fifo_level;

    int tests  = 0;
    int failed = 0;
    vec_t vecs [10];

    seg14_scroll_buffer #(
        .DIGITS     (12),
        .FIFO_DEPTH (16),
        .SCROLL_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .scroll_en  (scroll_en),
        .digit_idx  (digit_idx),
        .segm       (segm),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges and return just after the following falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_char   = 6'd0;
        scroll_en = 1'b0;
        digit_idx = 4'd0;

        // Window after "ALONZO" scrolls in for six ticks.
        vecs[0] = '{4'd6,  G_A};
        vecs[1] = '{4'd7,  G_L};
        vecs[2] = '{4'd8,  G_O};
        vecs[3] = '{4'd9,  G_N};
        vecs[4] = '{4'd10, G_Z};
        vecs[5] = '{4'd11, G_O};
        vecs[6] = '{4'd0,  14'd0};
        vecs[7] = '{4'd5,  14'd0};
        vecs[8] = '{4'd12, 14'd0};
        vecs[9] = '{4'd15, 14'd0};

        #12;
        check("rst_segm",     32'(segm),       32'd0);
        check("rst_level",    32'(fifo_level), 32'd0);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_in_ready", 32'(in_ready),   32'd1);

        // Writes start on the very first edge after reset release.
        rst_n = 1'b1;
        begin
            logic [5:0] alonzo [6] = '{6'd0, 6'd11, 6'd14, 6'd13, 6'd25, 6'd14};
            for (int i = 0; i < 6; i++) begin
                in_valid = 1'b1;
                in_char  = alonzo[i];
                step(1);
            end
        end
        in_valid = 1'b0;
        check("load_level", 32'(fifo_level), 32'd6);
        check("load_busy",  32'(busy),       32'd1);

        scroll_en = 1'b1;
        step(24);
        scroll_en = 1'b0;
        check("scroll_level", 32'(fifo_level), 32'd0);
        check("scroll_busy",  32'(busy),       32'd0);

        for (int i = 0; i < 10; i++) begin
            digit_idx = vecs[i].idx;
            step(1);
            check($sformatf("lookup_idx%0d", vecs[i].idx), 32'(segm), 32'(vecs[i].exp_segm));
        end

        // Fill to 16; the 17th character waits for a pop.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_char  = 6'(i);
            step(1);
        end
        check("full_level", 32'(fifo_level), 32'd16);
        check("full_ready", 32'(in_ready),   32'd0);
        in_char = 6'd16;
        step(2);
        check("full_held", 32'(fifo_level), 32'd16);
        scroll_en = 1'b1;
        step(3);
        check("full_pre_tick", 32'(fifo_level), 32'd16);
        step(1);
        check("full_pop_level", 32'(fifo_level), 32'd15);
        check("full_pop_ready", 32'(in_ready),   32'd1);
        scroll_en = 1'b0;
        step(1);
        check("full_17th_level", 32'(fifo_level), 32'd16);
        check("full_17th_ready", 32'(in_ready),   32'd0);
        in_valid  = 1'b0;
        digit_idx = 4'd11;
        step(1);
        check("full_pop_glyph", 32'(segm), 32'(G_A));

        // 16 ticks drain the FIFO, 12 more push everything off screen.
        scroll_en = 1'b1;
        step(112);
        scroll_en = 1'b0;
        check("drain_busy",  32'(busy),       32'd0);
        check("drain_level", 32'(fifo_level), 32'd0);
        for (int d = 0; d < 12; d++) begin
            digit_idx = 4'(d);
            step(1);
            check($sformatf("drain_idx%0d", d), 32'(segm), 32'd0);
        end

        // Write lands on the same edge as a tick with the FIFO empty.
        digit_idx = 4'd11;
        scroll_en = 1'b1;
        step(3);
        in_valid = 1'b1;
        in_char  = 6'd26;
        step(1);
        in_valid = 1'b0;
        check("wt_level", 32'(fifo_level), 32'd1);
        step(1);
        check("wt_space_in", 32'(segm), 32'd0);
        step(2);
        check("wt_level_hold", 32'(fifo_level), 32'd1);
        step(1);
        check("wt_popped", 32'(fifo_level), 32'd0);
        scroll_en = 1'b0;
        step(1);
        check("wt_glyph_zero", 32'(segm), 32'(G_ZERO));

        // Clear beats a simultaneous write and restarts the divider.
        in_valid = 1'b1;
        in_char  = 6'd1;
        step(1);
        in_char  = 6'd2;
        step(1);
        in_valid = 1'b0;
        check("pre_clr_level", 32'(fifo_level), 32'd2);
        scroll_en = 1'b1;
        step(2);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_char  = 6'd5;
        step(1);
        clr      = 1'b0;
        check("clr_level", 32'(fifo_level), 32'd0);
        check("clr_busy",  32'(busy),       32'd0);
        check("clr_ready", 32'(in_ready),   32'd1);
        in_char = 6'd0;
        step(1);
        in_valid = 1'b0;
        check("clr_window_space", 32'(segm), 32'd0);
        step(2);
        check("clr_div_no_tick", 32'(fifo_level), 32'd1);
        step(1);
        check("clr_div_tick", 32'(fifo_level), 32'd0);
        step(1);
        check("clr_glyph_a", 32'(segm), 32'(G_A));
        scroll_en = 1'b0;
        digit_idx = 4'd15;
        step(1);
        check("idx15", 32'(segm), 32'd0);

        // Asynchronous reset between clock edges.
        digit_idx = 4'd11;
        in_valid  = 1'b1;
        in_char   = 6'd3;
        step(1);
        in_valid  = 1'b0;
        check("pre_rst_segm", 32'(segm), 32'(G_A));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_segm",  32'(segm),       32'd0);
        check("async_rst_level", 32'(fifo_level), 32'd0);
        check("async_rst_ready", 32'(in_ready),   32'd1);
        check("async_rst_busy",  32'(busy),       32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_char  = 6'd7;
        step(1);
        in_valid = 1'b0;
        check("post_rst_write", 32'(fifo_level), 32'd1);
        check("post_rst_window", 32'(segm), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
